// File: rtl/door_actuator_if.sv
// Command/status bundle between the door controller and the actuator FSM.
//
// Signalling: there is no valid/ready handshake on this bundle. cmd_open,
// cmd_close and fault_clear are level-sampled on every rising clk edge (the
// controller sends single-cycle pulses); limit_* are raw end-stop levels.
// Every status output is registered state and changes only on a clk edge.
// state_dbg exposes the actuator FSM state for observation only.
interface door_actuator_if;
    logic       cmd_open;
    logic       cmd_close;
    logic       limit_open;
    logic       limit_close;
    logic       fault_clear;
    logic       motor_open;
    logic       motor_close;
    logic       is_open;
    logic       is_closed;
    logic       busy;
    logic       fault;
    logic [2:0] state_dbg;

    // Door controller / environment side.
    modport master (
        output cmd_open, cmd_close, limit_open, limit_close, fault_clear,
        input  motor_open, motor_close, is_open, is_closed, busy, fault, state_dbg
    );

    // Actuator side.
    modport slave (
        input  cmd_open, cmd_close, limit_open, limit_close, fault_clear,
        output motor_open, motor_close, is_open, is_closed, busy, fault, state_dbg
    );
endinterface

// File: rtl/door_actuator.sv
// Door motor actuator: Moore FSM driving an open/close motor between two
// end-stops, with travel timeout, dead time on direction reversal and a
// latched fault that is left by driving the door closed.
module door_actuator #(
    parameter int TRAVEL_MAX = 1000,
    parameter int DEAD_TIME  = 4
) (
    input  logic            clk,
    input  logic            rst,
    door_actuator_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPENED  = 3'd2,
        ST_CLOSING = 3'd3,
        ST_DEAD    = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    // Counter value seen on the last allowed cycle of a travel / of dead time.
    localparam logic [15:0] TRAVEL_LAST = 16'(TRAVEL_MAX - 1);
    localparam logic [15:0] DEAD_LAST   = 16'(DEAD_TIME - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] count;
    logic        target_open;       // direction to resume after dead time
    logic        target_open_next;

    logic limit_conflict;
    logic open_only;
    logic close_only;

    assign limit_conflict = bus.limit_open & bus.limit_close;
    assign open_only      = bus.cmd_open & ~bus.cmd_close;
    assign close_only     = bus.cmd_close & ~bus.cmd_open;

    // Next-state decision; within a state: limit conflict, end-stop, timeout, reversal.
    always_comb begin
        state_next       = state;
        target_open_next = target_open;
        case (state)
            ST_CLOSED: begin
                if (limit_conflict)  state_next = ST_FAULT;
                else if (open_only)  state_next = ST_OPENING;
            end
            ST_OPENED: begin
                if (limit_conflict)  state_next = ST_FAULT;
                else if (close_only) state_next = ST_CLOSING;
            end
            ST_OPENING: begin
                if (limit_conflict)              state_next = ST_FAULT;
                else if (bus.limit_open)         state_next = ST_OPENED;
                else if (count == TRAVEL_LAST)   state_next = ST_FAULT;
                else if (close_only) begin
                    state_next       = ST_DEAD;
                    target_open_next = 1'b0;
                end
            end
            ST_CLOSING: begin
                if (limit_conflict)              state_next = ST_FAULT;
                else if (bus.limit_close)        state_next = ST_CLOSED;
                else if (count == TRAVEL_LAST)   state_next = ST_FAULT;
                else if (open_only) begin
                    state_next       = ST_DEAD;
                    target_open_next = 1'b1;
                end
            end
            ST_DEAD: begin
                if (limit_conflict)              state_next = ST_FAULT;
                else if (count == DEAD_LAST)     state_next = target_open ? ST_OPENING : ST_CLOSING;
            end
            ST_FAULT: begin
                if (bus.fault_clear && !limit_conflict) state_next = ST_CLOSING;
            end
            default: state_next = ST_FAULT;
        endcase
    end

    // State, dwell counter (cleared on every change, saturating) and reversal target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CLOSED;
            count       <= 16'd0;
            target_open <= 1'b0;
        end else begin
            state       <= state_next;
            target_open <= target_open_next;
            if (state_next != state)    count <= 16'd0;
            else if (count != 16'hFFFF) count <= count + 16'd1;
        end
    end

    // Moore outputs decoded from the state register only.
    assign bus.motor_open  = (state == ST_OPENING);
    assign bus.motor_close = (state == ST_CLOSING);
    assign bus.is_open     = (state == ST_OPENED);
    assign bus.is_closed   = (state == ST_CLOSED);
    assign bus.busy        = (state == ST_OPENING) || (state == ST_CLOSING) || (state == ST_DEAD);
    assign bus.fault       = (state == ST_FAULT);
    assign bus.state_dbg   = state;

endmodule

// File: doc/door_actuator.md
DOOR_ACTUATOR -- requirements
Module: door_actuator

Interface
REQ-001 Parameter TRAVEL_MAX, default 1000: maximum motor-on cycles per travel before a fault.
REQ-002 Parameter DEAD_TIME, default 4: motor-off cycles inserted on a direction reversal (legal range 1..65535).
REQ-003 clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_open  input  1  open command, single-cycle pulse from the door controller.
REQ-006 cmd_close  input  1  close command, single-cycle pulse from the door controller.
REQ-007 limit_open  input  1  end-stop switch, door fully open.
REQ-008 limit_close  input  1  end-stop switch, door fully closed.
REQ-009 fault_clear  input  1  operator acknowledge of a fault.
REQ-010 motor_open  output  1  drive motor in the opening direction.
REQ-011 motor_close  output  1  drive motor in the closing direction.
REQ-012 is_open  output  1  door at rest, open.
REQ-013 is_closed  output  1  door at rest, closed.
REQ-014 busy  output  1  door in motion or in dead time.
REQ-015 fault  output  1  fault latched.

Function
REQ-016 The block SHALL be a Moore FSM with states CLOSED, OPENING, OPENED, CLOSING, DEAD, FAULT, plus a 16-bit cycle counter and a 1-bit reversal-target register.
REQ-017 Every output SHALL be a function of state only: motor_open=OPENING, motor_close=CLOSING, is_open=OPENED, is_closed=CLOSED, busy=OPENING|CLOSING|DEAD, fault=FAULT.
REQ-018 motor_open and motor_close SHALL never be 1 in the same cycle.
REQ-019 The counter SHALL clear to 0 on every state change and increment by 1 each cycle the state is unchanged, saturating at 16'hFFFF.
REQ-020 CLOSED: cmd_open=1 and cmd_close=0 SHALL move to OPENING; otherwise the state SHALL hold.
REQ-021 OPENED: cmd_close=1 and cmd_open=0 SHALL move to CLOSING; otherwise the state SHALL hold.
REQ-022 cmd_open and cmd_close both 1 in the same cycle SHALL be ignored in every state.
REQ-023 A command matching the current or travelling direction SHALL be ignored.
REQ-024 OPENING: limit_open=1 SHALL move to OPENED; otherwise counter==TRAVEL_MAX-1 SHALL move to FAULT; otherwise cmd_close alone SHALL store target=close and move to DEAD.
REQ-025 CLOSING SHALL mirror REQ-024, with limit_close moving to CLOSED and cmd_open storing target=open.
REQ-026 Within a state, priority SHALL be: limit-conflict fault, then end-stop, then timeout, then reversal command.
REQ-027 Therefore each travel SHALL drive the motor at most TRAVEL_MAX consecutive cycles.
REQ-028 DEAD: after DEAD_TIME cycles in DEAD (counter==DEAD_TIME-1), the FSM SHALL move to OPENING or CLOSING per target.
REQ-029 DEAD: all commands SHALL be ignored.
REQ-030 limit_open and limit_close both 1 in any non-FAULT state SHALL move to FAULT.
REQ-031 FAULT: motors SHALL be off and all commands ignored.
REQ-032 FAULT: fault_clear=1 with both limits not 1 SHALL move to CLOSING; fault_clear with both limits 1 SHALL hold FAULT.
REQ-033 A command sampled at edge N SHALL produce the new output values from edge N onward, i.e. one cycle of latency.

Reset
REQ-034 rst=1 at a clock edge SHALL force state CLOSED, counter 0, and target=close, overriding all other inputs, including mid-travel and in FAULT.
REQ-035 After reset, outputs SHALL be: motor_open=0, motor_close=0, is_open=0, is_closed=1, busy=0, fault=0.
REQ-036 Before the first reset the state SHALL be undefined; the bench SHALL apply rst for at least 1 cycle.

Verification
REQ-037 Normal open: reset, cmd_open pulse, limit_open raised 10 cycles later -> motor_open=1 for exactly 10 cycles, then is_open=1 and busy=0.
REQ-038 Timeout: TRAVEL_MAX=20, cmd_close from OPENED, no limit -> motor_close=1 for exactly 20 cycles, then fault=1 and motors 0; fault_clear -> motor_close=1 on the next cycle.
REQ-039 Reversal: DEAD_TIME=4, cmd_close at cycle 5 of OPENING -> motors 0 for exactly 4 cycles, then motor_close=1; motor_open and motor_close never overlap.
REQ-040 Simultaneous and ignored events: cmd_open=cmd_close=1 in CLOSED -> no state change; cmd_open during DEAD -> ignored; limit_open on the timeout cycle -> OPENED, not FAULT.
REQ-041 Limit conflict and reset: both limits high during OPENING -> fault=1 next cycle; rst mid-CLOSING -> is_closed=1, all else 0 next cycle.
